// File: rtl/ram_march_bist.sv
// March C- built-in self-test master for the single-port ram.
// Drives the ram port directly and checks data_read one cycle after each read.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start, ram port parked at zero
// WRITE0  | element 0: write background P0, addresses ascending
// RD      | elements 1-4: read issued at current address
// WR      | elements 1-4: previous read compared, element value written
// RD5     | element 5: read P0 at every address, ascending
// CHECK   | last element-5 read compared
// DONE    | one-cycle completion pulse, pass valid
module ram_march_bist #(
  parameter int                   D_WIDTH   = 16,
  parameter int                   A_WIDTH   = 4,
  parameter int                   A_MAX     = 16,
  parameter logic [D_WIDTH-1:0]   PATTERN   = 16'hA5A5,
  parameter int                   CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [A_WIDTH-1:0]   fail_addr,
  output logic [D_WIDTH-1:0]   fail_data,
  output logic [A_WIDTH-1:0]   mem_address,
  output logic [D_WIDTH-1:0]   mem_data_write,
  output logic                 mem_write_enable,
  input  logic [D_WIDTH-1:0]   mem_data_read
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE0, S_RD, S_WR, S_RD5, S_CHECK, S_DONE
  } state_t;

  localparam logic [D_WIDTH-1:0]   P0        = PATTERN;
  localparam logic [D_WIDTH-1:0]   P1        = ~PATTERN;
  localparam logic [A_WIDTH-1:0]   ADDR_LAST = A_WIDTH'(A_MAX - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;

  state_t               state;
  logic [2:0]           elem;
  logic                 cmp_valid;
  logic [D_WIDTH-1:0]   cmp_exp;
  logic                 mismatch;
  logic                 elem_down;
  logic                 at_end;
  logic [D_WIDTH-1:0]   rd_val;
  logic [D_WIDTH-1:0]   wr_val;

  // Elements 3 and 4 walk downwards; odd elements read P0, even read P1.
  assign elem_down = (elem == 3'd3) || (elem == 3'd4);
  assign at_end    = elem_down ? (mem_address == '0) : (mem_address == ADDR_LAST);
  assign rd_val    = elem[0] ? P0 : P1;
  assign wr_val    = ~rd_val;
  assign mismatch  = cmp_valid && (mem_data_read != cmp_exp);

  // Sequencer: state, element index and the registered ram port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      elem             <= 3'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_address      <= '0;
      mem_data_write   <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_WRITE0;
            busy             <= 1'b1;
            mem_address      <= '0;
            mem_data_write   <= P0;
            mem_write_enable <= 1'b1;
          end
        end
        S_WRITE0: begin
          if (mem_address == ADDR_LAST) begin
            state            <= S_RD;
            elem             <= 3'd1;
            mem_address      <= '0;
            mem_data_write   <= '0;
            mem_write_enable <= 1'b0;
          end else begin
            mem_address <= mem_address + 1'b1;
          end
        end
        S_RD: begin
          state            <= S_WR;
          mem_data_write   <= wr_val;
          mem_write_enable <= 1'b1;
        end
        S_WR: begin
          mem_data_write   <= '0;
          mem_write_enable <= 1'b0;
          if (at_end) begin
            if (elem == 3'd4) begin
              state       <= S_RD5;
              mem_address <= '0;
            end else begin
              state       <= S_RD;
              elem        <= elem + 3'd1;
              mem_address <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : '0;
            end
          end else begin
            state       <= S_RD;
            mem_address <= elem_down ? mem_address - 1'b1 : mem_address + 1'b1;
          end
        end
        S_RD5: begin
          if (mem_address == ADDR_LAST) begin
            state       <= S_CHECK;
            mem_address <= '0;
          end else begin
            mem_address <= mem_address + 1'b1;
          end
        end
        S_CHECK: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch the expected value and address alongside every issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
    end else begin
      cmp_valid <= (state == S_RD) || (state == S_RD5);
      cmp_exp   <= (state == S_RD5) ? P0 : rd_val;
    end
  end

  logic [A_WIDTH-1:0] cmp_addr;

  // Address of the outstanding read, needed because RD5 has already moved on.
  always_ff @(posedge clk) begin
    if (rst) cmp_addr <= '0;
    else     cmp_addr <= mem_address;
  end

  // Result registers: cleared by an accepted start, updated on each compare.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (mismatch) begin
        if (err_count != CNT_SAT) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= cmp_addr;
          fail_data <= mem_data_read;
        end
      end
      if (state == S_CHECK) pass <= (err_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural ram with one injectable stuck-at bit,
// fixed vector table, hand sequences for timing corners, random faults vs a model.
module tb_ram_march_bist;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [3:0]  fail_addr, mem_address;
  logic [15:0] fail_data, mem_data_write, mem_data_read;
  logic        mem_write_enable;

  logic        start_s, busy_s, done_s, pass_s, we_s;
  logic [1:0]  err_s;
  logic [3:0]  faddr_s, addr_s;
  logic [15:0] fdata_s, wd_s, rd_s;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  ram_march_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write_enable(mem_write_enable), .mem_data_read(mem_data_read)
  );

  ram_march_bist #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_addr(faddr_s), .fail_data(fdata_s),
    .mem_address(addr_s), .mem_data_write(wd_s),
    .mem_write_enable(we_s), .mem_data_read(rd_s)
  );

  // Ram model: write at the closing edge, registered read, optional stuck-at bit.
  logic [15:0] mem [16];
  bit          f_en;
  int          f_word, f_bit;
  bit          f_val;

  function automatic logic [15:0] faulty(input int a, input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (f_en && a == f_word) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_write;
    mem_data_read <= faulty(int'(mem_address), mem[mem_address]);
  end

  // Every word of the second ram reads back as zero.
  always @(posedge clk) rd_s <= 16'h0000;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: walk the March C- elements over an array with the same fault.
  function automatic void model(input bit en, input int w, input int b, input bit v,
                                output bit p, output int cnt, output int fa,
                                output logic [15:0] fd);
    logic [15:0] m [16];
    logic [15:0] pat [5];
    bit          down [5];
    logic [15:0] rv;
    int          a;
    pat  = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5};
    down = '{0, 0, 1, 1, 0};
    cnt = 0; fa = 0; fd = '0;
    for (int k = 0; k < 16; k++) m[k] = 16'hA5A5;
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < 16; k++) begin
        a  = down[e] ? 15 - k : k;
        rv = m[a];
        if (en && a == w) rv[b] = v;
        if (rv != pat[e]) begin
          if (cnt == 0) begin fa = a; fd = rv; end
          if (cnt < 255) cnt++;
        end
        if (e < 4) m[a] = ~pat[e];
      end
    end
    p = (cnt == 0);
  endfunction

  logic        tr_we   [300];
  logic [3:0]  tr_addr [300];
  logic [15:0] tr_data [300];
  logic        tr_busy [300];
  logic        tr_done [300];
  int          n_done, done_idx, busy_cnt;

  // Pulse start (accepted at edge 0), record index i = outputs after edge i.
  task automatic run(input int repulse_at);
    n_done = 0; done_idx = -1; busy_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_clears_err", err_count, 0);
    chk("start_clears_pass", pass, 0);
    chk("start_clears_faddr", fail_addr, 0);
    for (int i = 0; i < 300; i++) begin
      tr_we[i] = mem_write_enable; tr_addr[i] = mem_address; tr_data[i] = mem_data_write;
      tr_busy[i] = busy; tr_done[i] = done;
      if (busy) busy_cnt++;
      if (repulse_at >= 0 && i >= repulse_at && done_idx < 0) start = 1'b1;
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
        start = 1'b0;
      end
      if (done_idx >= 0 && i > done_idx + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen_once", n_done, 1);
    chk("done_cycle", done_idx, 161);
    chk("busy_cycles", busy_cnt, 161);
  endtask

  typedef struct {
    bit          fen;
    int          word;
    int          bitn;
    bit          val;
    bit          pass;
    int          cnt;
    int          faddr;
    logic [15:0] fdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit          mp;
    int          mc, ma, cyc;
    logic [15:0] md;

    vecs[0] = '{1, 5, 3, 1, 0, 3, 5, 16'hA5AD};
    vecs[1] = '{0, 0, 0, 0, 1, 0, 0, 16'h0000};
    vecs[2] = '{1, 0, 0, 0, 0, 3, 0, 16'hA5A4};
    vecs[3] = '{1, 15, 15, 1, 0, 2, 15, 16'hDA5A};
    vecs[4] = '{1, 8, 6, 0, 0, 2, 8, 16'h5A1A};
    vecs[5] = '{0, 0, 0, 0, 1, 0, 0, 16'h0000};

    for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
    f_en = 0; f_word = 0; f_bit = 0; f_val = 0;
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_data_write, 0);
    chk("rst_fdata", fail_data, 0);
    rst = 1'b0;

    // Fault-free run with port trace.
    run(-1);
    for (int k = 0; k < 16; k++) begin
      chk("e0_we", tr_we[k], 1);
      chk("e0_addr", tr_addr[k], k);
      chk("e0_data", tr_data[k], 16'hA5A5);
    end
    chk("e1_rd_we", tr_we[16], 0);
    chk("e1_rd_addr", tr_addr[16], 0);
    chk("e1_wr_we", tr_we[17], 1);
    chk("e1_wr_addr", tr_addr[17], 0);
    chk("e1_wr_data", tr_data[17], 16'h5A5A);
    chk("e3_first_addr", tr_addr[80], 15);
    chk("e3_first_we", tr_we[80], 0);
    chk("e3_wr_data", tr_data[81], 16'h5A5A);
    chk("e4_wr_data", tr_data[113], 16'hA5A5);
    chk("e5_addr_last", tr_addr[159], 15);
    chk("check_we", tr_we[160], 0);
    chk("done_addr", tr_addr[161], 0);
    chk("idle_busy", tr_busy[162], 0);
    chk("run1_pass", pass, 1);
    chk("run1_err", err_count, 0);

    // Fixed fault table, including a clean run after a failing one.
    for (int v = 0; v < 6; v++) begin
      f_en = vecs[v].fen; f_word = vecs[v].word; f_bit = vecs[v].bitn; f_val = vecs[v].val;
      run(-1);
      chk("vec_pass", pass, vecs[v].pass);
      chk("vec_err", err_count, vecs[v].cnt);
      chk("vec_faddr", fail_addr, vecs[v].faddr);
      chk("vec_fdata", fail_data, vecs[v].fdata);
    end

    // start re-pulsed mid-run and held into DONE.
    f_en = 0;
    run(20);
    chk("repulse_done_next", tr_done[done_idx + 1], 0);
    chk("repulse_idle_busy", tr_busy[done_idx + 2], 0);
    chk("repulse_idle_we", tr_we[done_idx + 2], 0);

    // Reset at cycle 50 of a faulty run.
    f_en = 1; f_word = 5; f_bit = 3; f_val = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre_abort_err", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_we", mem_write_enable, 0);
    chk("abort_err", err_count, 0);
    chk("abort_pass", pass, 0);
    n_done = 0;
    for (int i = 0; i < 200; i++) begin
      if (done || busy || mem_write_enable) n_done++;
      @(negedge clk);
    end
    chk("abort_quiet", n_done, 0);
    f_en = 0;
    run(-1);
    chk("after_abort_pass", pass, 1);

    // Random single stuck-at faults against the reference model.
    for (int r = 0; r < 10; r++) begin
      f_en = 1; f_word = $urandom_range(15); f_bit = $urandom_range(15);
      f_val = 1'($urandom_range(1));
      model(f_en, f_word, f_bit, f_val, mp, mc, ma, md);
      run(-1);
      chk("rnd_pass", pass, mp);
      chk("rnd_err", err_count, mc);
      chk("rnd_faddr", fail_addr, ma);
      chk("rnd_fdata", fail_data, md);
    end

    // All-zero ram with a 2-bit error counter.
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_done_cycle", cyc, 161);
    chk("sat_err", err_s, 3);
    chk("sat_faddr", faddr_s, 0);
    chk("sat_fdata", fdata_s, 0);
    chk("sat_pass", pass_s, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
